fetch_queue: RTL and testbench



---
 rtl/fetch_queue_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch front-end types and processor constants
// Purpose: processor constants reused by fetch, decode and stall control, the
//          FIFO entry layout, the fetch stream state encoding and a PC helper.
// Ports:   none (package).
package fetch_queue_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'd0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } stream_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  // Word addresses wrap naturally at 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH x 64-bit circular prefetch buffer
// Purpose: holds {pc, insn} pairs between imem response and decode.
// Ports:   clock, reset (async, active-low); push/din write an entry; pop
//          retires the head; flush empties the buffer; dout is the registered
//          head entry; count is the number of valid entries.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;

  assign full = (count == CNT_W'(DEPTH));
  assign dout = mem[rd_ptr];

  // Pointers wrap modulo DEPTH on their own; count disambiguates full/empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // The issuer's credit check must keep responses out of a full buffer.
  always_ff @(posedge clock) begin
    if (reset && !flush) begin
      a_no_push_full: assert (!(push && full));
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with prefetch FIFO
// Purpose: issues the imem word address stream, captures returned words into
//          a prefetch FIFO and hands (pc, insn) pairs to decode; flushes on
//          X-stage redirects.
// Ports:   clock, reset (async, active-low); address_imem/q_imem to imem;
//          redirect_valid/redirect_pc from X; out_valid/out_ready handshake
//          with out_pc, out_pc_next, out_insn to decode; occupancy count.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [31:0]            address_imem,
  input  logic [31:0]            q_imem,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_pc_next,
  output logic [31:0]            out_insn,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  stream_state_e state;

  logic          push;
  logic          pop;
  logic          issue;
  logic [SUM_W-1:0] credit_sum;
  fetch_entry_t  fifo_din;
  fetch_entry_t  fifo_dout;

  // A redirect kills both the returning response and any pop this cycle.
  assign push = inflight && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  // Entries already held, the response landing now and the one this issue
  // would produce must all fit, so a response never meets a full FIFO.
  assign credit_sum = SUM_W'(occupancy) + SUM_W'(inflight)
                    + SUM_W'(push) - SUM_W'(pop);
  assign issue      = !redirect_valid && (credit_sum < SUM_W'(DEPTH));

  assign address_imem = fetch_pc;
  assign fifo_din     = '{pc: req_pc, insn: q_imem};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (occupancy)
  );

  assign out_valid   = (occupancy != '0);
  assign out_pc      = out_valid ? fifo_dout.pc : 32'd0;
  assign out_pc_next = pc_inc(out_pc);
  assign out_insn    = out_valid ? fifo_dout.insn : NOP_WORD;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= 32'd0;
      inflight <= 1'b0;
      state    <= ST_FLUSH;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      state    <= ST_FLUSH;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= pc_inc(fetch_pc);
      end
      case (state)
        ST_FLUSH: state <= ST_RUN;
        ST_RUN:   state <= issue ? ST_RUN : ST_HOLD;
        ST_HOLD:  state <= issue ? ST_RUN : ST_HOLD;
        default:  state <= ST_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scoreboard bench for fetch_queue
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [31:0] out_insn;
  logic [$clog2(DEPTH):0] occupancy;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'd0), .NOP_WORD(32'd0)) dut (
    .clock          (clock),
    .reset          (reset),
    .address_imem   (address_imem),
    .q_imem         (q_imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_next    (out_pc_next),
    .out_insn       (out_insn),
    .occupancy      (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // imem model: word i holds i+100, data returned one cycle after address.
  always @(posedge clock) q_imem <= address_imem + 32'd100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_expected(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i));
  endtask

  // Sample point: every visible head must be the next expected PC.
  task automatic to_neg();
    @(negedge clock);
    if (!redirect_valid) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          chk("sb_pc", out_pc, exp_q[0]);
          chk("sb_insn", out_insn, exp_q[0] + 32'd100);
          chk("sb_pc_next", out_pc_next, exp_q[0] + 32'd1);
          if (out_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end else begin
        chk("sb_bubble_nop", out_insn, 32'd0);
      end
    end
  endtask

  task automatic to_pos();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    to_neg();
    to_pos();
  endtask

  task automatic release_reset(input logic ready);
    load_expected(32'd0);
    @(posedge clock);
    #1;
    out_ready = ready;
    reset = 1'b1;
  endtask

  initial begin
    int base;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b1;

    // Reset state
    #2;
    chk("rst_addr", address_imem, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_insn", out_insn, 32'd0);
    chk("rst_pc", out_pc, 32'd0);

    // Streaming from reset: valid in cycle 2, then one per cycle
    release_reset(1'b1);
    to_neg(); chk("lat_c0_valid", 32'(out_valid), 32'd0); to_pos();
    to_neg(); chk("lat_c1_valid", 32'(out_valid), 32'd0); to_pos();
    to_neg();
    chk("lat_c2_valid", 32'(out_valid), 32'd1);
    chk("lat_c2_pc", out_pc, 32'd0);
    chk("lat_c2_insn", out_insn, 32'd100);
    to_pos();
    for (int i = 0; i < 4; i++) begin
      to_neg(); chk("stream_valid", 32'(out_valid), 32'd1); to_pos();
    end

    // Decode stalled: FIFO saturates, address stops at DEPTH
    reset = 1'b0;
    release_reset(1'b0);
    for (int i = 0; i < 9; i++) tick();
    to_neg();
    chk("stall_occ", 32'(occupancy), 32'(DEPTH));
    chk("stall_addr", address_imem, 32'd4);
    chk("stall_valid", 32'(out_valid), 32'd1);
    to_pos();
    out_ready = 1'b1;
    base = pops;
    for (int i = 0; i < 12; i++) tick();
    chk("stall_pops", 32'((pops - base) >= 8), 32'd1);

    // Redirect with occupancy 3 and a response in flight, ready high
    reset = 1'b0;
    release_reset(1'b0);
    for (int i = 0; i < 5; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd40;
    out_ready      = 1'b1;
    to_neg();
    chk("redir_occ_before", 32'(occupancy), 32'd3);
    chk("redir_valid_before", 32'(out_valid), 32'd1);
    to_pos();
    redirect_valid = 1'b0;
    load_expected(32'd40);
    to_neg();
    chk("redir_occ_after", 32'(occupancy), 32'd0);
    chk("redir_valid_after", 32'(out_valid), 32'd0);
    to_pos();
    to_neg(); chk("redir_lat_c1", 32'(out_valid), 32'd0); to_pos();
    to_neg(); chk("redir_lat_c2", 32'(out_valid), 32'd1); chk("redir_pc", out_pc, 32'd40); to_pos();
    for (int i = 0; i < 8; i++) tick();

    // PC wrap plus FIFO pointer wrap under random ready
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    load_expected(32'hFFFF_FFFE);
    base = pops;
    for (int i = 0; i < 400 && (pops - base) < 3 * DEPTH + 2; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("wrap_pops", 32'((pops - base) >= 3 * DEPTH), 32'd1);

    // Asynchronous reset mid-stream with occupancy 2
    reset = 1'b0;
    release_reset(1'b0);
    for (int i = 0; i < 3; i++) tick();
    #2;
    chk("mid_occ_before", 32'(occupancy), 32'd2);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_insn", out_insn, 32'd0);
    chk("mid_rst_addr", address_imem, 32'd0);
    chk("mid_rst_pc", out_pc, 32'd0);
    release_reset(1'b1);
    to_neg(); chk("mid_lat_c0", 32'(out_valid), 32'd0); to_pos();
    to_neg(); chk("mid_lat_c1", 32'(out_valid), 32'd0); to_pos();
    to_neg(); chk("mid_lat_c2", 32'(out_valid), 32'd1); chk("mid_pc", out_pc, 32'd0); to_pos();
    for (int i = 0; i < 4; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
